ps2_kbd_tx: RTL and testbench

PS2_KBD_TX -- requirements
Module: ps2_kbd_tx

---
 rtl/ps2_kbd_tx.sv | 230 +++++++++++++++++++++++
 tb/tb_ps2_kbd_tx.sv | 392 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_kbd_tx.sv
// PS/2 device-side keyboard transmitter: 4-entry scan-code FIFO feeding an 11-bit framer.
// Define PS2_TX_BREAK_EN to store a break flag per entry and prefix such codes with an 0xF0 frame.
module ps2_kbd_tx #(
    parameter int HALF_PERIOD = 8,
    parameter int GAP_CYCLES  = 16
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    input  logic       tx_break,
    output logic       tx_ready,
    output logic       ps2_clk,
    output logic       ps2_data,
    output logic       busy,
    output logic [2:0] fifo_count
);

`ifdef PS2_TX_BREAK_EN
    localparam int ENTRY_W = 9;
`else
    localparam int ENTRY_W = 8;
`endif
    localparam logic [7:0] HALF_LAST  = 8'(HALF_PERIOD - 1);
    localparam logic [7:0] GAP_LAST   = 8'(GAP_CYCLES - 1);
    localparam logic [7:0] BREAK_CODE = 8'hF0;
    localparam logic [3:0] STOP_IDX   = 4'd10;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        BIT_HIGH = 2'd1,
        BIT_LOW  = 2'd2,
        GAP      = 2'd3
    } state_t;

    // Frame: stop, odd parity, data MSB..LSB, start (bit 0 goes out first).
    function automatic logic [10:0] make_frame(input logic [7:0] code);
        return {1'b1, ~(^code), code, 1'b0};
    endfunction

    state_t             state_q, state_d;
    logic [7:0]         cnt_q, cnt_d;
    logic [3:0]         bit_q, bit_d;
    logic [10:0]        frame_q, frame_d;
    logic [ENTRY_W-1:0] mem_q [4];
    logic [1:0]         wr_ptr_q, rd_ptr_q;
    logic [2:0]         count_q;
    logic               push_s, pop_s;
    logic               ps2_clk_q, ps2_data_q, busy_q;
    logic               ps2_clk_d, ps2_data_d, busy_d;
    logic [ENTRY_W-1:0] head_s, wr_entry_s;

`ifdef PS2_TX_BREAK_EN
    logic               pend_q, pend_d;
    logic [7:0]         pend_code_q, pend_code_d;
    assign wr_entry_s = {tx_break, tx_data};
`else
    logic               unused_break_s;
    assign unused_break_s = tx_break;
    assign wr_entry_s     = tx_data;
`endif

    assign tx_ready   = (count_q != 3'd4);
    assign push_s     = tx_valid && tx_ready;
    assign head_s     = mem_q[rd_ptr_q];
    assign fifo_count = count_q;
    assign ps2_clk    = ps2_clk_q;
    assign ps2_data   = ps2_data_q;
    assign busy       = busy_q;

    // Next-state logic of the framer FSM, including FIFO pop.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        frame_d = frame_q;
        pop_s   = 1'b0;
`ifdef PS2_TX_BREAK_EN
        pend_d      = pend_q;
        pend_code_d = pend_code_q;
`endif
        case (state_q)
            IDLE: begin
`ifdef PS2_TX_BREAK_EN
                // A pending code after an 0xF0 prefix goes out before the next pop.
                if (pend_q) begin
                    frame_d = make_frame(pend_code_q);
                    pend_d  = 1'b0;
                    state_d = BIT_HIGH;
                    cnt_d   = 8'd0;
                    bit_d   = 4'd0;
                end else if (count_q != 3'd0) begin
                    pop_s   = 1'b1;
                    state_d = BIT_HIGH;
                    cnt_d   = 8'd0;
                    bit_d   = 4'd0;
                    if (head_s[8]) begin
                        frame_d     = make_frame(BREAK_CODE);
                        pend_d      = 1'b1;
                        pend_code_d = head_s[7:0];
                    end else begin
                        frame_d = make_frame(head_s[7:0]);
                    end
                end else begin
                    state_d = IDLE;
                end
`else
                if (count_q != 3'd0) begin
                    pop_s   = 1'b1;
                    frame_d = make_frame(head_s[7:0]);
                    state_d = BIT_HIGH;
                    cnt_d   = 8'd0;
                    bit_d   = 4'd0;
                end else begin
                    state_d = IDLE;
                end
`endif
            end
            BIT_HIGH: begin
                if (cnt_q == HALF_LAST) begin
                    state_d = BIT_LOW;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            BIT_LOW: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d = 8'd0;
                    if (bit_q == STOP_IDX) begin
                        state_d = GAP;
                    end else begin
                        bit_d   = bit_q + 4'd1;
                        state_d = BIT_HIGH;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = IDLE;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 8'd0;
                bit_d   = 4'd0;
            end
        endcase
    end

    // Line levels decoded from the current state; registered below so the pins never glitch.
    always_comb begin
        ps2_clk_d  = 1'b1;
        ps2_data_d = 1'b1;
        busy_d     = 1'b0;
        case (state_q)
            BIT_HIGH: begin
                ps2_data_d = frame_q[bit_q];
                busy_d     = 1'b1;
            end
            BIT_LOW: begin
                ps2_clk_d  = 1'b0;
                ps2_data_d = frame_q[bit_q];
                busy_d     = 1'b1;
            end
            GAP: begin
                busy_d = 1'b1;
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    // State, FIFO bookkeeping and output registers.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= IDLE;
            cnt_q      <= 8'd0;
            bit_q      <= 4'd0;
            frame_q    <= 11'h7FF;
            wr_ptr_q   <= 2'd0;
            rd_ptr_q   <= 2'd0;
            count_q    <= 3'd0;
            ps2_clk_q  <= 1'b1;
            ps2_data_q <= 1'b1;
            busy_q     <= 1'b0;
`ifdef PS2_TX_BREAK_EN
            pend_q      <= 1'b0;
            pend_code_q <= 8'd0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            frame_q    <= frame_d;
            ps2_clk_q  <= ps2_clk_d;
            ps2_data_q <= ps2_data_d;
            busy_q     <= busy_d;
`ifdef PS2_TX_BREAK_EN
            pend_q      <= pend_d;
            pend_code_q <= pend_code_d;
`endif
            if (push_s) begin
                wr_ptr_q <= wr_ptr_q + 2'd1;
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + 2'd1;
            end
            case ({push_s, pop_s})
                2'b10:   count_q <= count_q + 3'd1;
                2'b01:   count_q <= count_q - 3'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    // FIFO storage; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (resetn && push_s) begin
            mem_q[wr_ptr_q] <= wr_entry_s;
        end
    end

endmodule

// File: tb/tb_ps2_kbd_tx.sv
// Self-checking bench for ps2_kbd_tx: a line-level PS/2 receiver model decodes the pins and
// scenario tasks compare decoded frames and timing against values derived from byte contents.
module tb_ps2_kbd_tx;
    localparam int HP  = 4;
    localparam int GAP = 16;
    localparam int BIT_CYC = 2 * HP;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = 8'd0;
    logic       tx_break = 1'b0;
    logic       tx_ready, ps2_clk, ps2_data, busy;
    logic [2:0] fifo_count;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    ps2_kbd_tx #(.HALF_PERIOD(HP), .GAP_CYCLES(GAP)) dut (
        .clk(clk), .resetn(resetn), .tx_valid(tx_valid), .tx_data(tx_data),
        .tx_break(tx_break), .tx_ready(tx_ready), .ps2_clk(ps2_clk),
        .ps2_data(ps2_data), .busy(busy), .fifo_count(fifo_count)
    );

    initial forever #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Receiver model: shift ps2_data on every ps2_clk falling edge, 11 bits per frame.
    logic [10:0] frames_q[$];
    int          fall_q[$];
    int          rise_q[$];
    int          bfall_q[$];
    initial begin
        logic [10:0] sh;
        int nbits;
        logic pclk, pbusy;
        nbits = 0; pclk = 1'b1; pbusy = 1'b0; sh = 11'd0;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                nbits = 0;
            end else begin
                if (pclk && !ps2_clk) begin
                    fall_q.push_back(cyc);
                    sh[nbits] = ps2_data;
                    nbits++;
                    if (nbits == 11) begin
                        frames_q.push_back(sh);
                        nbits = 0;
                    end
                end
                if (!pclk && ps2_clk) rise_q.push_back(cyc);
                if (pbusy && !busy) bfall_q.push_back(cyc);
            end
            pclk = ps2_clk;
            pbusy = busy;
        end
    end

    function automatic logic [10:0] exp_frame(input logic [7:0] b);
        logic par;
        par = ($countones(b) % 2 == 0) ? 1'b1 : 1'b0;
        return {1'b1, par, b, 1'b0};
    endfunction

    task automatic clear_mon();
        frames_q.delete(); fall_q.delete(); rise_q.delete(); bfall_q.delete();
    endtask

    task automatic wait_frames(input int n, input int budget, output bit ok);
        int t = 0;
        while (frames_q.size() < n && t < budget) begin
            @(negedge clk);
            t++;
        end
        ok = (frames_q.size() >= n);
    endtask

    task automatic wait_idle(output bit ok);
        int run = 0;
        int t = 0;
        while (run < 4 && t < 3000) begin
            @(negedge clk);
            if (!busy && fifo_count == 3'd0) run++; else run = 0;
            t++;
        end
        ok = (run >= 4);
    endtask

    task automatic push_one(input logic [7:0] d, input logic brk, output bit ok);
        int t = 0;
        @(negedge clk);
        tx_valid = 1'b1; tx_data = d; tx_break = brk;
        while (!tx_ready && t < 2000) begin
            @(negedge clk);
            t++;
        end
        ok = tx_ready;
        @(posedge clk); #1;
        tx_valid = 1'b0; tx_break = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        resetn = 1'b0; tx_valid = 1'b1; tx_data = 8'($urandom_range(0, 255));
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({ps2_clk, ps2_data, busy, tx_ready} !== 4'b1101) begin
            failures++;
            $display("FAIL reset_lines: got clk/data/busy/ready=%b required 1101",
                     {ps2_clk, ps2_data, busy, tx_ready});
        end
        checks++;
        if (fifo_count !== 3'd0) begin
            failures++;
            $display("FAIL reset_count: got %0d required 0", fifo_count);
        end
        @(negedge clk);
        tx_valid = 1'b0; resetn = 1'b1;
    endtask

    task automatic test_single();
        bit ok;
        int n, bad;
        wait_idle(ok);
        clear_mon();
        @(negedge clk);
        tx_valid = 1'b1; tx_data = 8'h1C;
        @(posedge clk); #1;
        n = cyc; tx_valid = 1'b0;
        checks++;
        if (fifo_count !== 3'd1) begin
            failures++;
            $display("FAIL single_accept_count: got %0d required 1", fifo_count);
        end
        @(posedge clk); #1;
        checks++;
        if (ps2_data !== 1'b1) begin
            failures++;
            $display("FAIL single_n1_data: got %b required 1", ps2_data);
        end
        @(posedge clk); #1;
        checks++;
        if ({ps2_clk, ps2_data} !== 2'b10) begin
            failures++;
            $display("FAIL single_start_latency: got clk/data=%b required 10", {ps2_clk, ps2_data});
        end
        wait_frames(1, 300, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL single_timeout: got %0d frames required 1", frames_q.size());
        end else begin
            checks++;
            if (frames_q[0] !== exp_frame(8'h1C)) begin
                failures++;
                $display("FAIL single_frame: got %b required %b", frames_q[0], exp_frame(8'h1C));
            end
            bad = 0;
            for (int i = 1; i < fall_q.size(); i++)
                if (fall_q[i] - fall_q[i-1] != BIT_CYC) bad++;
            checks++;
            if (fall_q.size() != 11 || bad != 0) begin
                failures++;
                $display("FAIL single_falls: got %0d falls %0d bad spacings required 11 and 0",
                         fall_q.size(), bad);
            end
            checks++;
            if (fall_q[0] != n + 2 + HP) begin
                failures++;
                $display("FAIL single_first_fall: got cycle %0d required %0d", fall_q[0], n + 2 + HP);
            end
        end
        for (int t = 0; t < 100 && bfall_q.size() == 0; t++) @(negedge clk);
        checks++;
        if (bfall_q.size() == 0 || rise_q.size() == 0) begin
            failures++;
            $display("FAIL busy_fall: got no busy fall required one");
        end else if (bfall_q[0] - rise_q[$] != GAP) begin
            failures++;
            $display("FAIL busy_fall: got %0d cycles after stop required %0d", bfall_q[0] - rise_q[$], GAP);
        end
    endtask

    task automatic test_parity_b2b();
        bit ok;
        logic [7:0] vals [3];
        logic       pars [3];
        int idle;
        vals[0] = 8'h00; vals[1] = 8'hFF; vals[2] = 8'h01;
        pars[0] = 1'b1;  pars[1] = 1'b1;  pars[2] = 1'b0;
        wait_idle(ok);
        clear_mon();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tx_valid = 1'b1; tx_data = vals[i];
            @(posedge clk);
        end
        #1 tx_valid = 1'b0;
        wait_frames(3, 600, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL b2b_timeout: got %0d frames required 3", frames_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (frames_q[i] !== exp_frame(vals[i]) || frames_q[i][9] !== pars[i]) begin
                    failures++;
                    $display("FAIL b2b_frame%0d: got %b required %b parity %b", i, frames_q[i],
                             exp_frame(vals[i]), pars[i]);
                end
            end
            for (int k = 1; k < 3; k++) begin
                idle = fall_q[11*k] - HP - rise_q[11*k-1];
                checks++;
                if (idle != GAP + 1) begin
                    failures++;
                    $display("FAIL b2b_gap%0d: got %0d idle cycles required %0d", k, idle, GAP + 1);
                end
            end
        end
    endtask

    task automatic test_fifo_full();
        bit ok, rdy, full_seen;
        logic [7:0] vals [6];
        int acc [6];
        int k, ready_bad, stall_bad;
        for (int i = 0; i < 6; i++) vals[i] = 8'($urandom_range(0, 255));
        k = 0; ready_bad = 0; stall_bad = 0; full_seen = 1'b0;
        wait_idle(ok);
        clear_mon();
        @(negedge clk);
        tx_valid = 1'b1; tx_data = vals[0];
        for (int t = 0; t < 400 && k < 6; t++) begin
            rdy = tx_ready;
            if (fifo_count == 3'd4) full_seen = 1'b1;
            if (fifo_count == 3'd4 && tx_ready) ready_bad++;
            if (!tx_ready && fifo_count != 3'd4) stall_bad++;
            @(posedge clk); #1;
            if (rdy) begin
                acc[k] = cyc;
                k++;
            end
            @(negedge clk);
            if (k < 6) tx_data = vals[k]; else tx_valid = 1'b0;
        end
        tx_valid = 1'b0;
        checks++;
        if (k != 6 || !full_seen || ready_bad != 0 || stall_bad != 0) begin
            failures++;
            $display("FAIL full_flow: got accepted=%0d full=%0d ready_bad=%0d stall_bad=%0d required 6 1 0 0",
                     k, full_seen, ready_bad, stall_bad);
        end
        wait_frames(6, 1200, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL full_timeout: got %0d frames required 6", frames_q.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (frames_q[i] !== exp_frame(vals[i])) begin
                    failures++;
                    $display("FAIL full_order%0d: got %b required %b", i, frames_q[i], exp_frame(vals[i]));
                end
            end
            checks++;
            if (k == 6 && acc[5] != fall_q[11] - HP) begin
                failures++;
                $display("FAIL full_late_accept: got cycle %0d required %0d", acc[5], fall_q[11] - HP);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int nf;
        wait_idle(ok);
        clear_mon();
        for (int i = 0; i < 3; i++) push_one(8'($urandom_range(0, 255)), 1'b0, ok);
        for (int t = 0; t < 200 && fall_q.size() < 5; t++) @(negedge clk);
        checks++;
        if (fall_q.size() < 5) begin
            failures++;
            $display("FAIL midreset_reach_bit3: got %0d falls required 5", fall_q.size());
        end
        @(negedge clk);
        resetn = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({ps2_clk, ps2_data, busy} !== 3'b110 || fifo_count !== 3'd0) begin
            failures++;
            $display("FAIL midreset_lines: got clk/data/busy=%b count=%0d required 110 and 0",
                     {ps2_clk, ps2_data, busy}, fifo_count);
        end
        @(negedge clk);
        resetn = 1'b1;
        nf = fall_q.size();
        repeat (300) @(negedge clk);
        checks++;
        if (fall_q.size() != nf || frames_q.size() != 0) begin
            failures++;
            $display("FAIL midreset_silent: got %0d extra falls %0d frames required 0 0",
                     fall_q.size() - nf, frames_q.size());
        end
    endtask

    task automatic test_break();
        bit ok;
        logic [7:0] exp_q[$];
`ifdef PS2_TX_BREAK_EN
        exp_q = '{8'hF0, 8'h1C};
`else
        exp_q = '{8'h1C};
`endif
        wait_idle(ok);
        clear_mon();
        push_one(8'h1C, 1'b1, ok);
        wait_frames(exp_q.size(), 800, ok);
        repeat (300) @(negedge clk);
        checks++;
        if (frames_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL break_frames: got %0d frames required %0d", frames_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (frames_q[i] !== exp_frame(exp_q[i])) begin
                    failures++;
                    $display("FAIL break_frame%0d: got %b required %b", i, frames_q[i], exp_frame(exp_q[i]));
                end
            end
        end
    endtask

    task automatic test_loopback();
        bit ok;
        int push_bad;
        logic [7:0] seq_q[$];
        seq_q = '{8'h1C, 8'h32, 8'hF0, 8'h1C};
        for (int i = 0; i < 6; i++) seq_q.push_back(8'($urandom_range(0, 255)));
        push_bad = 0;
        wait_idle(ok);
        clear_mon();
        foreach (seq_q[i]) begin
            repeat ($urandom_range(0, 30)) @(negedge clk);
            push_one(seq_q[i], 1'b0, ok);
            if (!ok) push_bad++;
        end
        wait_frames(seq_q.size(), 3000, ok);
        checks++;
        if (!ok || push_bad != 0) begin
            failures++;
            $display("FAIL loop_timeout: got %0d frames %0d stuck pushes required %0d and 0",
                     frames_q.size(), push_bad, seq_q.size());
        end else begin
            foreach (seq_q[i]) begin
                checks++;
                if (frames_q[i][8:1] !== seq_q[i] || frames_q[i] !== exp_frame(seq_q[i])) begin
                    failures++;
                    $display("FAIL loop_byte%0d: got %b required %b", i, frames_q[i], exp_frame(seq_q[i]));
                end
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_parity_b2b();
        test_fifo_full();
        test_reset_mid();
        test_break();
        test_loopback();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
